// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready handshake, flush-to-bubble and a saturating stall
// counter. Define PIPE_STAGE_SKID_EN to add a skid entry that registers in_ready.
module pipe_stage_reg #(
  parameter int unsigned DATA_W = 128,
  parameter int unsigned CTRL_W = 16,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  input  logic              flush,
  input  logic              clr_cnt,
  output logic [CNT_W-1:0]  stall_cnt
);

  // Ones over the control field; a shift by >= DATA_W yields zero, so CTRL_W == DATA_W works.
  localparam logic [DATA_W-1:0] CtrlMask = ~({DATA_W{1'b1}} << CTRL_W);
  localparam logic [CNT_W-1:0]  CntMax   = '1;

  logic              accept;
  logic              drain;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

  assign accept = in_valid && in_ready;
  assign drain  = out_valid_q && out_ready;

`ifdef PIPE_STAGE_SKID_EN

  logic              skid_valid_q, skid_valid_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;

  // Registered-state ready: no out_ready -> in_ready path.
  assign in_ready = rst && !skid_valid_q;

  always_comb begin
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    if (flush) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
      out_data_d   = out_data_q & ~CtrlMask;
    end else if (skid_valid_q) begin
      if (drain) begin
        out_data_d   = skid_data_q;
        skid_valid_d = 1'b0;
      end
    end else if (out_valid_q) begin
      if (accept && !drain) begin
        skid_valid_d = 1'b1;
        skid_data_d  = in_data;
      end else if (accept) begin
        out_data_d = in_data;
      end else if (drain) begin
        out_valid_d = 1'b0;
        out_data_d  = out_data_q & ~CtrlMask;
      end
    end else if (accept) begin
      out_valid_d = 1'b1;
      out_data_d  = in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
    end else begin
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
    end
  end

`else

  assign in_ready = rst && (!out_valid_q || out_ready);

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    if (flush) begin
      out_valid_d = 1'b0;
      out_data_d  = out_data_q & ~CtrlMask;
    end else if (accept) begin
      out_valid_d = 1'b1;
      out_data_d  = in_data;
    end else if (drain) begin
      out_valid_d = 1'b0;
      out_data_d  = out_data_q & ~CtrlMask;
    end
  end

`endif

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (clr_cnt) begin
      stall_cnt_d = '0;
    end else if (out_valid_q && !out_ready && (stall_cnt_q != CntMax)) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      stall_cnt_q <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg; scoreboard of accepted payloads vs drained outputs.
// Expectations adapt to PIPE_STAGE_SKID_EN where the two builds differ.
module tb_pipe_stage_reg;

  localparam int unsigned DW = 32;
  localparam int unsigned CW = 8;
  localparam int unsigned NW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          flush;
  logic          clr_cnt;
  logic [NW-1:0] stall_cnt;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] held_q[$];  // payloads the stage should currently hold, oldest first
  logic [DW-1:0] exp_q[$];   // expected payload for each observed drain
  logic [DW-1:0] obs_q[$];   // payload seen at each drain

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  pipe_stage_reg #(
    .DATA_W(DW),
    .CTRL_W(CW),
    .CNT_W (NW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .flush    (flush),
    .clr_cnt  (clr_cnt),
    .stall_cnt(stall_cnt)
  );

  function automatic logic [DW-1:0] pl(input int i);
    logic [15:0] mid;
    mid = i[15:0];
    return {8'hA5, mid, 8'(i + 1)};
  endfunction

  // Sample handshakes mid-cycle, update the scoreboard, then advance past the next edge.
  task automatic tick(output bit acc);
    @(negedge clk);
    acc = in_valid && in_ready;
    if (!rst || flush) begin
      held_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        obs_q.push_back(out_data);
        if (held_q.size() > 0) exp_q.push_back(held_q.pop_front());
        else exp_q.push_back({DW{1'bx}});
      end
      if (acc) held_q.push_back(in_data);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic step();
    bit d;
    tick(d);
  endtask

  task automatic test_reset();
    rst = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; flush = 1'b0; clr_cnt = 1'b0;
    step();
    step();
    checks++;
    if (out_valid !== 1'b0 || out_data !== '0 || stall_cnt !== '0) begin
      errors++;
      $display("FAIL reset_state: valid=%b data=%h cnt=%0d, want 0/0/0", out_valid, out_data,
               stall_cnt);
    end
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_ready_low: in_ready=%b want 0", in_ready);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready_high: in_ready=%b want 1", in_ready);
    end
  endtask

  task automatic test_streaming();
    bit acc;
    int n;
    logic [DW-1:0] last, got, want;
    obs_q.delete(); exp_q.delete();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      in_data = pl(i);
      tick(acc);
      checks++;
      if (!acc || out_valid !== 1'b1 || out_data !== pl(i)) begin
        errors++;
        $display("FAIL stream_latency: acc=%b valid=%b data=%h want 1/1/%h", acc, out_valid,
                 out_data, pl(i));
      end
    end
    in_valid = 1'b0;
    step();
    last = pl(10);
    checks++;
    if (out_valid !== 1'b0 || out_data[CW-1:0] !== '0 || out_data[DW-1:CW] !== last[DW-1:CW])
    begin
      errors++;
      $display("FAIL stream_bubble: valid=%b data=%h want 0 with ctrl 0 upper %h", out_valid,
               out_data, last[DW-1:CW]);
    end
    checks++;
    if (stall_cnt !== '0) begin
      errors++;
      $display("FAIL stream_stall_cnt: cnt=%0d want 0", stall_cnt);
    end
    n = 0;
    while (obs_q.size() > 0) begin
      got = obs_q.pop_front();
      want = exp_q.pop_front();
      n++;
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL stream_order: got %h want %h", got, want);
      end
    end
    checks++;
    if (n != 10) begin
      errors++;
      $display("FAIL stream_count: drained %0d want 10", n);
    end
  endtask

  task automatic test_backpressure();
    bit acc;
    int k, n;
    logic [DW-1:0] got, want;
    logic [DW-1:0] v[3];
    v = '{32'h0A0A_A00A, 32'h0B0B_B00B, 32'h0C0C_C00C};
    obs_q.delete(); exp_q.delete();
    clr_cnt = 1'b1;
    step();
    clr_cnt = 1'b0;
    out_ready = 1'b0;
    k = 0;
    in_valid = 1'b1;
    in_data = v[0];
    repeat (6) begin
      tick(acc);
      if (acc) k++;
      in_valid = (k < 3);
      if (k < 3) in_data = v[k];
    end
    checks++;
    if (out_valid !== 1'b1 || out_data !== v[0] || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL bp_hold: valid=%b data=%h ready=%b want 1/%h/0", out_valid, out_data,
               in_ready, v[0]);
    end
    checks++;
`ifdef PIPE_STAGE_SKID_EN
    if (k != 2) begin
`else
    if (k != 1) begin
`endif
      errors++;
      $display("FAIL bp_accepted: accepted %0d during stall", k);
    end
    checks++;
    if (stall_cnt !== 4'd5) begin
      errors++;
      $display("FAIL bp_stall_cnt: cnt=%0d want 5", stall_cnt);
    end
    out_ready = 1'b1;
    for (int t = 0; t < 20 && (k < 3 || out_valid); t++) begin
      tick(acc);
      if (acc) k++;
      in_valid = (k < 3);
      if (k < 3) in_data = v[k];
    end
    checks++;
    if (stall_cnt !== 4'd5 || held_q.size() != 0) begin
      errors++;
      $display("FAIL bp_release: cnt=%0d held=%0d want 5/0", stall_cnt, held_q.size());
    end
    n = 0;
    while (obs_q.size() > 0) begin
      got = obs_q.pop_front();
      want = exp_q.pop_front();
      checks++;
      if (got !== want || got !== v[n]) begin
        errors++;
        $display("FAIL bp_order: got %h want %h", got, v[n]);
      end
      n++;
    end
    checks++;
    if (n != 3) begin
      errors++;
      $display("FAIL bp_count: drained %0d want 3", n);
    end
  endtask

  task automatic test_flush();
    bit acc;
    logic [DW-1:0] v1, v2;
    v1 = 32'h1100_0011;
    v2 = 32'h2200_0022;
    obs_q.delete(); exp_q.delete();
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_data = v1;
    tick(acc);
    in_data = v2;
    tick(acc);
    flush = 1'b1;
    in_data = 32'hDD00_00DD;
    tick(acc);
    flush = 1'b0;
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || out_data[CW-1:0] !== '0 || out_data[DW-1:CW] !== v1[DW-1:CW]) begin
      errors++;
      $display("FAIL flush_bubble: valid=%b data=%h want 0 ctrl 0 upper %h", out_valid,
               out_data, v1[DW-1:CW]);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL flush_ready: in_ready=%b want 1", in_ready);
    end
    out_ready = 1'b1;
    repeat (4) step();
    checks++;
    if (out_valid !== 1'b0 || obs_q.size() != 0) begin
      errors++;
      $display("FAIL flush_discard: valid=%b drains=%0d want 0/0", out_valid, obs_q.size());
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_saturation();
    bit acc;
    clr_cnt = 1'b1;
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_data = pl(50);
    tick(acc);
    clr_cnt = 1'b0;
    in_valid = 1'b0;
    repeat (20) step();
    checks++;
    if (stall_cnt !== 4'd15) begin
      errors++;
      $display("FAIL cnt_saturate: cnt=%0d want 15", stall_cnt);
    end
    clr_cnt = 1'b1;
    step();
    checks++;
    if (stall_cnt !== 4'd0) begin
      errors++;
      $display("FAIL cnt_clear_wins: cnt=%0d want 0", stall_cnt);
    end
    clr_cnt = 1'b0;
    step();
    checks++;
    if (stall_cnt !== 4'd1) begin
      errors++;
      $display("FAIL cnt_resume: cnt=%0d want 1", stall_cnt);
    end
  endtask

  task automatic test_reset_mid();
    bit acc;
    in_valid = 1'b1;
    in_data = pl(51);
    tick(acc);
    in_valid = 1'b0;
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_ready_low: in_ready=%b want 0", in_ready);
    end
    step();
    checks++;
    if (out_valid !== 1'b0 || out_data !== '0 || stall_cnt !== '0) begin
      errors++;
      $display("FAIL rst_mid_state: valid=%b data=%h cnt=%0d want 0/0/0", out_valid, out_data,
               stall_cnt);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_ready_high: in_ready=%b want 1", in_ready);
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_ready_mirror();
    bit acc;
    logic [DW-1:0] got, want;
    out_ready = 1'b1;
    in_valid = 1'b1;
    in_data = pl(60);
    tick(acc);
    for (int i = 0; i < 8; i++) begin
      out_ready = (i % 2 == 0);
      in_data = pl(61 + i);
      #1;
`ifdef PIPE_STAGE_SKID_EN
      begin
        logic r0;
        r0 = in_ready;
        out_ready = ~out_ready;
        #1;
        checks++;
        if (in_ready !== r0) begin
          errors++;
          $display("FAIL skid_ready_path: in_ready=%b changed with out_ready, want %b", in_ready,
                   r0);
        end
        out_ready = ~out_ready;
        #1;
      end
`else
      checks++;
      if (out_valid !== 1'b1 || in_ready !== out_ready) begin
        errors++;
        $display("FAIL ready_mirror: valid=%b in_ready=%b want 1/%b", out_valid, in_ready,
                 out_ready);
      end
`endif
      tick(acc);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int t = 0; t < 10 && out_valid; t++) step();
    checks++;
    if (held_q.size() != 0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL mirror_drain: held=%0d valid=%b want 0/0", held_q.size(), out_valid);
    end
    while (obs_q.size() > 0) begin
      got = obs_q.pop_front();
      want = exp_q.pop_front();
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL mirror_order: got %h want %h", got, want);
      end
    end
  endtask

  task automatic test_random();
    bit acc;
    int n, d;
    logic [DW-1:0] got, want;
    obs_q.delete(); exp_q.delete();
    n = 0;
    for (int t = 0; t < 2000 && n < 100; t++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      in_data = $urandom;
      out_ready = ($urandom_range(0, 2) != 0);
      tick(acc);
      if (acc) n++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int t = 0; t < 10 && out_valid; t++) step();
    checks++;
    if (n != 100 || held_q.size() != 0) begin
      errors++;
      $display("FAIL random_accept: accepted=%0d held=%0d want 100/0", n, held_q.size());
    end
    d = 0;
    while (obs_q.size() > 0) begin
      got = obs_q.pop_front();
      want = exp_q.pop_front();
      d++;
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL random_order: got %h want %h", got, want);
      end
    end
    checks++;
    if (d != 100) begin
      errors++;
      $display("FAIL random_count: drained %0d want 100", d);
    end
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_flush();
    test_saturation();
    test_reset_mid();
    test_ready_mirror();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
